tcm_banked_mp: RTL

TCM_BANKED_MP -- requirements
Module: tcm_banked_mp

---
 rtl/tcm_pkg.sv | 22 ++
 rtl/tcm_bank_router.sv | 50 +++++
 rtl/tcm_banked_mp.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tcm_pkg.sv
// Shared constants, FSM state type and sizing helpers for the banked TCM.
// The constants describe the default build and are used as submodule defaults.
package tcm_pkg;

    localparam int unsigned BANK_NUM        = 8;
    localparam int unsigned BANK_ADDR_WIDTH = $clog2(BANK_NUM);
    localparam int unsigned ROW_WIDTH       = $clog2(65536 / BANK_NUM);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } tcm_state_e;

    function automatic int unsigned bank_addr_width(input int unsigned bus_bytes);
        return $clog2(bus_bytes);
    endfunction

    function automatic int unsigned row_width(input int unsigned size, input int unsigned bus_bytes);
        return $clog2(size / bus_bytes);
    endfunction

endpackage

// File: rtl/tcm_bank_router.sv
// Maps one byte-addressed access onto the banks: per-bank row (r or r+1),
// lane<->bank rotation of a W-bit-per-byte vector, and the range check.
module tcm_bank_router import tcm_pkg::*; #(
    parameter int unsigned BUS_BYTES  = BANK_NUM,
    parameter int unsigned BAW        = BANK_ADDR_WIDTH,
    parameter int unsigned RW         = ROW_WIDTH,
    parameter int unsigned TCM_SIZE   = 65536,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned W          = 8,
    parameter bit          TO_LANES   = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [BUS_BYTES*W-1:0] vec_i,
    output logic [BUS_BYTES*W-1:0] vec_o,
    output logic [RW-1:0]          row_o [BUS_BYTES],
    output logic                   in_range_o
);

    // addr + BUS_BYTES - 1 < TCM_SIZE, evaluated without any wrap-around
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(TCM_SIZE - BUS_BYTES + 1);

    logic [BAW-1:0] ofs;
    logic [RW-1:0]  row;

    assign ofs        = addr_i[BAW-1:0];
    assign row        = addr_i[BAW +: RW];
    assign in_range_o = ({1'b0, addr_i} < LIMIT);

    always_comb begin
        for (int unsigned b = 0; b < BUS_BYTES; b++) begin
            row_o[b] = (BAW'(b) < ofs) ? row + RW'(1) : row;
        end
    end

    always_comb begin
        logic [BAW-1:0] idx;
        idx   = '0;
        vec_o = '0;
        for (int unsigned i = 0; i < BUS_BYTES; i++) begin
            // lane i reads bank (ofs+i); bank i takes lane (i-ofs)
            if (TO_LANES) begin
                idx = BAW'(i) + ofs;
            end else begin
                idx = BAW'(i) - ofs;
            end
            vec_o[i*W +: W] = vec_i[int'(idx)*W +: W];
        end
    end

endmodule

// File: rtl/tcm_banked_mp.sv
// Byte-banked tightly-coupled memory: one write port, READ_PORTS read ports,
// any alignment, latency-1 write-first reads, zero-fill after reset.
module tcm_banked_mp import tcm_pkg::*; #(
    parameter int unsigned BUS_BYTES      = BANK_NUM,
    parameter int unsigned TCM_SIZE       = 65536,
    parameter int unsigned READ_PORTS     = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter              IMAGE_PATH     = "",
    parameter bit          IMAGE_INIT     = 1'b0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [READ_PORTS-1:0]                   rd_req,
    input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]   rd_addr,
    output logic [READ_PORTS-1:0]                   rd_rsp_valid,
    output logic [READ_PORTS-1:0][BUS_BYTES*8-1:0]  rd_data,
    output logic [READ_PORTS-1:0]                   rd_err,
    input  logic                                    wr_req,
    input  logic [ADDR_WIDTH-1:0]                   wr_addr,
    input  logic [BUS_BYTES*8-1:0]                  wr_data,
    input  logic [BUS_BYTES-1:0]                    wr_be,
    output logic                                    wr_ready,
    output logic                                    wr_err,
    output logic                                    init_done
);

    localparam int unsigned BAW  = bank_addr_width(BUS_BYTES);
    localparam int unsigned RW   = row_width(TCM_SIZE, BUS_BYTES);
    localparam int unsigned ROWS = TCM_SIZE / BUS_BYTES;
    localparam int unsigned DW   = BUS_BYTES * 8;

    if (IMAGE_INIT && CLEAR_ON_RESET) begin : g_cfg_err
        $error("tcm_banked_mp: IMAGE_INIT (%s) cannot be combined with CLEAR_ON_RESET", IMAGE_PATH);
    end

    tcm_state_e    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          init_done_q;
    logic          wr_err_q;
    logic          clearing;
    logic          wr_acc;
    logic          wr_in_range;

    logic [BUS_BYTES*9-1:0] wr_lane, wr_bank;
    logic [RW-1:0]          wr_row    [BUS_BYTES];
    logic [BUS_BYTES-1:0]   bk_we;
    logic [RW-1:0]          bk_waddr  [BUS_BYTES];
    logic [7:0]             bk_wdata  [BUS_BYTES];

    assign clearing  = (state_q == ST_CLEAR);
    // Requests are served only once init_done is visible, one cycle after READY
    assign wr_acc    = wr_req && init_done_q;
    assign wr_ready  = init_done_q;
    assign wr_err    = wr_err_q;
    assign init_done = init_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_q == ST_READY);
            wr_err_q    <= wr_acc && !wr_in_range;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + RW'(1);
                if (cnt_q == RW'(ROWS - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: ;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        wr_lane = '0;
        for (int unsigned k = 0; k < BUS_BYTES; k++) begin
            wr_lane[k*9 +: 9] = {wr_be[k], wr_data[k*8 +: 8]};
        end
    end

    tcm_bank_router #(
        .BUS_BYTES  (BUS_BYTES),
        .BAW        (BAW),
        .RW         (RW),
        .TCM_SIZE   (TCM_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .W          (9),
        .TO_LANES   (1'b0)
    ) u_wr_router (
        .addr_i     (wr_addr),
        .vec_i      (wr_lane),
        .vec_o      (wr_bank),
        .row_o      (wr_row),
        .in_range_o (wr_in_range)
    );

    always_comb begin
        for (int unsigned b = 0; b < BUS_BYTES; b++) begin
            if (clearing) begin
                bk_we[b]    = 1'b1;
                bk_waddr[b] = cnt_q;
                bk_wdata[b] = '0;
            end else begin
                bk_we[b]    = wr_acc && wr_in_range && wr_bank[b*9 + 8];
                bk_waddr[b] = wr_row[b];
                bk_wdata[b] = wr_bank[b*9 +: 8];
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [RW-1:0] rrow [BUS_BYTES];
        logic [DW-1:0] bank_rd, lane_rd;
        logic          rin;
        logic          valid_q, err_q;
        logic [DW-1:0] data_q;
        logic          acc;

        assign acc = rd_req[p] && init_done_q;

        tcm_bank_router #(
            .BUS_BYTES  (BUS_BYTES),
            .BAW        (BAW),
            .RW         (RW),
            .TCM_SIZE   (TCM_SIZE),
            .ADDR_WIDTH (ADDR_WIDTH),
            .W          (8),
            .TO_LANES   (1'b1)
        ) u_rd_router (
            .addr_i     (rd_addr[p]),
            .vec_i      (bank_rd),
            .vec_o      (lane_rd),
            .row_o      (rrow),
            .in_range_o (rin)
        );

        for (genvar b = 0; b < BUS_BYTES; b++) begin : g_bank
            logic [7:0] mem [ROWS];

            always_ff @(posedge clk) begin
                if (bk_we[b]) begin
                    mem[bk_waddr[b]] <= bk_wdata[b];
                end
            end

            // write-first: a same-cycle write to this row is forwarded
            assign bank_rd[b*8 +: 8] = (bk_we[b] && (bk_waddr[b] == rrow[b])) ? bk_wdata[b]
                                                                              : mem[rrow[b]];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= acc;
                if (acc) begin
                    data_q <= rin ? lane_rd : '0;
                    err_q  <= !rin;
                end
            end
        end

        assign rd_rsp_valid[p] = valid_q;
        assign rd_err[p]       = err_q;
        assign rd_data[p]      = data_q;
    end

endmodule
